// File: rtl/multicycle_control.sv
// Multicycle MIPS control unit: Moore FSM driving datapath strobes, PC enable, overflow trap and illegal-opcode pulse.
// Latency: outputs decode the state register (PCEn adds Zero combinationally); lw 5, sw/R/addi 4, beq/j 3 cycles.
// Backpressure: none; advances one state per clock, and reset aborts the current instruction asynchronously.
//
// Ports: clk, reset (async active-high); Op[5:0] opcode, Zero / overflow ALU flags;
//        datapath strobes IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
//        ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0]; PCEn, ovf_trap, illegal_op, state[3:0] (debug).
// Optional feature: define MC_JUMP_EN to support the j instruction (JUMP state). Without it, j is illegal.
module multicycle_control (
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       overflow,
   output logic       IorD,
   output logic       IRWrite,
   output logic       MemWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic       Branch,
   output logic       PCWrite,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] PCSrc,
   output logic       PCEn,
   output logic       ovf_trap,
   output logic       illegal_op,
   output logic [3:0] state
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXECUTE = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JUMP    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_RTYP = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
`ifdef MC_JUMP_EN
   localparam logic [5:0] OP_J    = 6'b000010;
`endif

   state_t state_q, state_d;
   logic   ovf_q;
   logic   illegal_q, illegal_d;
   logic   pc_write_raw, ir_write_raw;

   // State, overflow capture and illegal-opcode pulse registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ovf_q     <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         // Only the edge leaving an ALU-execute state keeps the flag; every other edge clears it.
         ovf_q     <= ((state_q == S_EXECUTE) || (state_q == S_ADDIEX)) & overflow;
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic. Op is looked at only in DECODE and MEMADR.
   always_comb begin
      state_d   = S_FETCH;
      illegal_d = 1'b0;
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (Op)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYP:      state_d = S_EXECUTE;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
`ifdef MC_JUMP_EN
               OP_J:         state_d = S_JUMP;
`endif
               default: begin
                  state_d   = S_FETCH;
                  illegal_d = 1'b1;
               end
            endcase
         end
         S_MEMADR:  state_d = (Op == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXECUTE: state_d = S_ALUWB;
         S_ADDIEX:  state_d = S_ADDIWB;
         // Terminal states, JUMP and unused codes all return to FETCH.
         default:   state_d = S_FETCH;
      endcase
   end

   // Moore output decode; anything not set in a state stays 0.
   always_comb begin
      IorD         = 1'b0;
      ir_write_raw = 1'b0;
      MemWrite     = 1'b0;
      RegDst       = 1'b0;
      MemtoReg     = 1'b0;
      RegWrite     = 1'b0;
      ALUSrcA      = 1'b0;
      Branch       = 1'b0;
      pc_write_raw = 1'b0;
      ALUSrcB      = 2'b00;
      ALUOp        = 2'b00;
      PCSrc        = 2'b00;
      ovf_trap     = 1'b0;
      case (state_q)
         S_FETCH: begin
            ir_write_raw = 1'b1;
            ALUSrcB      = 2'b01;
            pc_write_raw = 1'b1;
         end
         S_DECODE: ALUSrcB = 2'b11;
         S_MEMADR, S_ADDIEX: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMRD: IorD = 1'b1;
         S_MEMWR: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_MEMWB: begin
            MemtoReg = 1'b1;
            RegWrite = 1'b1;
         end
         S_EXECUTE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
         end
         S_ALUWB: begin
            RegDst   = 1'b1;
            RegWrite = ~ovf_q;
            ovf_trap = ovf_q;
         end
         S_ADDIWB: begin
            RegWrite = ~ovf_q;
            ovf_trap = ovf_q;
         end
         S_BRANCH: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b01;
            PCSrc   = 2'b01;
            Branch  = 1'b1;
         end
`ifdef MC_JUMP_EN
         S_JUMP: begin
            PCSrc        = 2'b10;
            pc_write_raw = 1'b1;
         end
`endif
         default: ;
      endcase
   end

   // While reset is held the FETCH decode is visible, but nothing may load the PC or IR.
   assign PCWrite    = pc_write_raw & ~reset;
   assign IRWrite    = ir_write_raw & ~reset;
   assign PCEn       = PCWrite | (Branch & Zero);
   assign illegal_op = illegal_q;
   assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through the FSM and checks strobes per cycle.
// Latency: inputs change and outputs are checked on the falling edge; the DUT moves on the rising edge.
// Backpressure: none; one summary line at the end.
module tb_multicycle_control;

   logic       clk, reset, Zero, overflow;
   logic [5:0] Op;
   logic       IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite;
   logic [1:0] ALUSrcB, ALUOp, PCSrc;
   logic       PCEn, ovf_trap, illegal_op;
   logic [3:0] state;

   int n_cmp = 0;
   int n_err = 0;

   multicycle_control dut (
      .clk(clk), .reset(reset), .Op(Op), .Zero(Zero), .overflow(overflow),
      .IorD(IorD), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .Branch(Branch), .PCWrite(PCWrite),
      .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCEn(PCEn), .ovf_trap(ovf_trap),
      .illegal_op(illegal_op), .state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      reset = 1'b1; Op = 6'b000000; Zero = 1'b1; overflow = 1'b0;
      #2;
      n_cmp++;
      if (state !== 4'd0 || illegal_op !== 1'b0) begin
         n_err++; $display("FAIL reset_state: state=%0d illegal_op=%b, want 0/0", state, illegal_op);
      end
      n_cmp++;
      if ({PCWrite, IRWrite, PCEn} !== 3'b000 || ALUSrcB !== 2'b01 || IorD !== 1'b0) begin
         n_err++; $display("FAIL reset_outputs: PCWrite/IRWrite/PCEn=%b%b%b ALUSrcB=%b IorD=%b, want 000/01/0",
                           PCWrite, IRWrite, PCEn, ALUSrcB, IorD);
      end
      @(negedge clk); @(negedge clk);
      n_cmp++;
      if (state !== 4'd0) begin
         n_err++; $display("FAIL reset_held: state=%0d, want 0", state);
      end
      Zero = 1'b0;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({PCWrite, IRWrite, PCEn} !== 3'b111) begin
         n_err++; $display("FAIL fetch_after_reset: PCWrite/IRWrite/PCEn=%b%b%b, want 111", PCWrite, IRWrite, PCEn);
      end
   endtask

   task automatic test_lw;
      logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
      Op = 6'b100011;
      for (int i = 0; i < 6; i++) begin
         n_cmp++;
         if (state !== exp_s[i] || RegWrite !== (exp_s[i] == 4'd4) || MemtoReg !== (exp_s[i] == 4'd4)) begin
            n_err++; $display("FAIL lw cyc%0d: state=%0d RegWrite=%b MemtoReg=%b, want state=%0d both=%b",
                              i, state, RegWrite, MemtoReg, exp_s[i], exp_s[i] == 4'd4);
         end
         if (i < 5) @(negedge clk);
      end
   endtask

   task automatic test_reset_mid;
      Op = 6'b100011;
      @(negedge clk); @(negedge clk); @(negedge clk);
      n_cmp++;
      if (state !== 4'd3 || IorD !== 1'b1) begin
         n_err++; $display("FAIL reset_mid_memrd: state=%0d IorD=%b, want 3/1", state, IorD);
      end
      reset = 1'b1;
      #1;
      n_cmp++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0 || {PCWrite, IRWrite, PCEn} !== 3'b000) begin
         n_err++; $display("FAIL reset_mid_async: state=%0d MemWrite=%b RegWrite=%b PC/IR/En=%b%b%b, want 0/0/0/000",
                           state, MemWrite, RegWrite, PCWrite, IRWrite, PCEn);
      end
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd0 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_hold: state=%0d MemWrite=%b RegWrite=%b, want 0/0/0", state, MemWrite, RegWrite);
      end
      reset = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1 || MemWrite !== 1'b0 || RegWrite !== 1'b0) begin
         n_err++; $display("FAIL reset_mid_release: state=%0d MemWrite=%b RegWrite=%b, want 1/0/0", state, MemWrite, RegWrite);
      end
      Op = 6'b111111;
      @(negedge clk);
   endtask

   task automatic test_branch;
      logic z;
      Op = 6'b000100;
      for (int k = 0; k < 2; k++) begin
         z = (k == 0);
         Zero = z;
         @(negedge clk);
         n_cmp++;
         if (state !== 4'd1 || PCEn !== 1'b0) begin
            n_err++; $display("FAIL beq_decode z=%b: state=%0d PCEn=%b, want 1/0", z, state, PCEn);
         end
         @(negedge clk);
         n_cmp++;
         if (state !== 4'd8 || PCEn !== z || PCSrc !== 2'b01 || Branch !== 1'b1 || ALUOp !== 2'b01 || PCWrite !== 1'b0) begin
            n_err++; $display("FAIL beq_branch z=%b: state=%0d PCEn=%b PCSrc=%b Branch=%b ALUOp=%b PCWrite=%b, want 8/%b/01/1/01/0",
                              z, state, PCEn, PCSrc, Branch, ALUOp, PCWrite, z);
         end
         @(negedge clk);
         n_cmp++;
         if (state !== 4'd0) begin
            n_err++; $display("FAIL beq_return z=%b: state=%0d, want 0", z, state);
         end
      end
      Zero = 1'b0;
   endtask

   task automatic test_rtype_ovf;
      logic ov;
      Op = 6'b000000;
      for (int k = 0; k < 2; k++) begin
         ov = (k == 0);
         @(negedge clk); @(negedge clk);
         n_cmp++;
         if (state !== 4'd6 || ALUOp !== 2'b10 || ALUSrcB !== 2'b00 || ALUSrcA !== 1'b1) begin
            n_err++; $display("FAIL rtype_exec: state=%0d ALUOp=%b ALUSrcB=%b ALUSrcA=%b, want 6/10/00/1",
                              state, ALUOp, ALUSrcB, ALUSrcA);
         end
         overflow = ov;
         @(negedge clk);
         overflow = 1'b0;
         n_cmp++;
         if (state !== 4'd7 || RegWrite !== ~ov || ovf_trap !== ov || RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
            n_err++; $display("FAIL rtype_wb ov=%b: state=%0d RegWrite=%b ovf_trap=%b RegDst=%b MemtoReg=%b, want 7/%b/%b/1/0",
                              ov, state, RegWrite, ovf_trap, RegDst, MemtoReg, ~ov, ov);
         end
         @(negedge clk);
         n_cmp++;
         if (state !== 4'd0 || ovf_trap !== 1'b0) begin
            n_err++; $display("FAIL rtype_trap_clear ov=%b: state=%0d ovf_trap=%b, want 0/0", ov, state, ovf_trap);
         end
      end
   endtask

   task automatic test_illegal;
      Op = 6'b111111;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1 || illegal_op !== 1'b0) begin
         n_err++; $display("FAIL illegal_decode: state=%0d illegal_op=%b, want 1/0", state, illegal_op);
      end
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd0 || illegal_op !== 1'b1) begin
         n_err++; $display("FAIL illegal_pulse: state=%0d illegal_op=%b, want 0/1", state, illegal_op);
      end
      Op = 6'b000010;
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd1 || illegal_op !== 1'b0) begin
         n_err++; $display("FAIL illegal_pulse_end: state=%0d illegal_op=%b, want 1/0", state, illegal_op);
      end
      @(negedge clk);
`ifdef MC_JUMP_EN
      n_cmp++;
      if (state !== 4'd11 || PCWrite !== 1'b1 || PCSrc !== 2'b10 || PCEn !== 1'b1) begin
         n_err++; $display("FAIL jump_state: state=%0d PCWrite=%b PCSrc=%b PCEn=%b, want 11/1/10/1", state, PCWrite, PCSrc, PCEn);
      end
      @(negedge clk);
      n_cmp++;
      if (state !== 4'd0 || illegal_op !== 1'b0) begin
         n_err++; $display("FAIL jump_return: state=%0d illegal_op=%b, want 0/0", state, illegal_op);
      end
`else
      n_cmp++;
      if (state !== 4'd0 || illegal_op !== 1'b1) begin
         n_err++; $display("FAIL jump_illegal: state=%0d illegal_op=%b, want 0/1", state, illegal_op);
      end
`endif
   endtask

   task automatic test_back_to_back;
      logic [3:0] exp_s [9] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd0, 4'd1, 4'd9, 4'd10, 4'd0};
      logic [1:0] exp_b [9] = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
      Op = 6'b101011;
      for (int i = 0; i < 9; i++) begin
         n_cmp++;
         if (state !== exp_s[i] || MemWrite !== (exp_s[i] == 4'd5) || ALUSrcB !== exp_b[i] ||
             RegWrite !== (exp_s[i] == 4'd10)) begin
            n_err++; $display("FAIL b2b cyc%0d: state=%0d MemWrite=%b ALUSrcB=%b RegWrite=%b, want %0d/%b/%b/%b",
                              i, state, MemWrite, ALUSrcB, RegWrite, exp_s[i], exp_s[i] == 4'd5, exp_b[i], exp_s[i] == 4'd10);
         end
         if (i == 4) begin
            n_cmp++;
            if (illegal_op !== 1'b0) begin
               n_err++; $display("FAIL b2b_op_ignored: illegal_op=%b, want 0", illegal_op);
            end
         end
         // Garbage Op outside DECODE/MEMADR must not matter; then queue addi.
         if (i == 3) Op = 6'b111111;
         if (i == 4) Op = 6'b001000;
         if (i < 8) @(negedge clk);
      end
   endtask

   initial begin
      test_reset();
      test_lw();
      test_reset_mid();
      test_branch();
      test_rtype_ovf();
      test_illegal();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters: none; the state encoding is fixed by REQ-010.
REQ-002 clk  in  1  single clock, all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high.
REQ-004 Op  in  6  opcode from instruction register, instr[31:26].
REQ-005 Zero  in  1  ALU zero flag.
REQ-006 overflow  in  1  ALU signed-overflow flag.
REQ-007 IorD, IRWrite, MemWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, Branch, PCWrite  out  1 each  datapath strobes/selects.
REQ-008 ALUSrcB  out  2  selects: 00 RD2, 01 const 4, 10 SignImm, 11 SignImm<<2; ALUOp  out  2  00 add, 01 sub, 10 funct-decoded; PCSrc  out  2  00 ALU result, 01 ALUOut, 10 jump target.
REQ-009 PCEn  out  1  PC load enable; ovf_trap  out  1  overflow event pulse; illegal_op  out  1  unsupported-opcode pulse; state  out  4  current state, debug.

Function
REQ-010 States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11; codes 12-15 go to FETCH on the next edge with all strobes low.
REQ-011 Transitions: FETCH->DECODE; DECODE by Op: 100011/101011->MEMADR, 000000->EXECUTE, 000100->BRANCH, 001000->ADDIEX, 000010->JUMP (see REQ-022), any other->FETCH.
REQ-012 MEMADR->MEMRD if Op=100011, else MEMWR; MEMRD->MEMWB; EXECUTE->ALUWB; ADDIEX->ADDIWB; MEMWB, MEMWR, ALUWB, BRANCH, ADDIWB, JUMP->FETCH.
REQ-013 Op is sampled only in DECODE and in MEMADR; changes on Op in other states have no effect.
REQ-014 Moore outputs, decoded from the state register only; unlisted outputs are 0 in every state.
REQ-015 FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1. DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00.
REQ-016 MEMADR and ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. MEMRD: IorD=1. MEMWR: IorD=1, MemWrite=1. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1.
REQ-017 EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. JUMP: PCSrc=10, PCWrite=1.
REQ-018 PCEn = PCWrite | (Branch & Zero), combinational with zero added latency; Zero is ignored outside BRANCH.
REQ-019 Overflow flag register ovf_q captures overflow at the EXECUTE->ALUWB and ADDIEX->ADDIWB edges and clears on every other edge.
REQ-020 ALUWB: RegDst=1, MemtoReg=0, RegWrite=~ovf_q; ADDIWB: RegDst=0, MemtoReg=0, RegWrite=~ovf_q; ovf_trap=ovf_q in these two states only (one-cycle pulse).
REQ-021 illegal_op is a registered one-cycle pulse asserted in the FETCH cycle following a DECODE that saw an unsupported Op.
REQ-022 Instruction latency in cycles: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-023 reset asserted: state=FETCH, ovf_q=0, illegal_op=0 immediately, independent of clk.
REQ-024 Reset mid-instruction aborts it; the first edge after deassertion moves FETCH->DECODE with FETCH outputs driven in the cycle before that edge.
REQ-025 While reset is high, outputs equal the FETCH decode except PCWrite=0, IRWrite=0 and PCEn=0.

Configuration
REQ-026 Macro MC_JUMP_EN defined: Op=000010 in DECODE -> JUMP, per REQ-017.
REQ-027 Macro MC_JUMP_EN undefined: JUMP state is absent, code 11 behaves per REQ-010 (-> FETCH), and Op=000010 is illegal per REQ-021.

Verification
REQ-028 Reset pulse mid-MEMRD -> state=0 asynchronously; next edge state=1; MemWrite=0, RegWrite=0 throughout.
REQ-029 Op=100011, held -> states 0,1,2,3,4,0; RegWrite=1 and MemtoReg=1 only in state 4; five cycles.
REQ-030 Op=000100, Zero=1 in BRANCH -> PCEn=1, PCSrc=01 for one cycle; repeat with Zero=0 -> PCEn=0; three cycles.
REQ-031 Op=000000, overflow=1 during EXECUTE -> ALUWB with RegWrite=0 and ovf_trap=1 for one cycle; with overflow=0 -> RegWrite=1, ovf_trap=0.
REQ-032 Op=111111 -> states 0,1,0 and illegal_op=1 in the second FETCH; Op=000010 -> state 11 with PCWrite=1 when MC_JUMP_EN is defined, illegal_op pulse when it is undefined.
REQ-033 Op=101011 followed by Op=001000 -> states 0,1,2,5,0,1,9,10,0; MemWrite=1 only in state 5; ALUSrcB=10 in states 2 and 9.
